// File: rtl/dds_wave_analyzer.sv
// Waveform analyzer for a DDS loopback: measures period, high time, peaks and lock from a sample stream.
// Optional build macro WAVE_AVG_EN: Period reports the mean of the last four raw periods.
module dds_wave_analyzer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int HYST   = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Sample_Valid,
  input  logic [DATA_W-1:0] Sample,
  output logic [CNT_W-1:0]  Period,
  output logic [CNT_W-1:0]  High_Time,
  output logic [DATA_W-1:0] Peak_Max,
  output logic [DATA_W-1:0] Peak_Min,
  output logic              Meas_Valid,
  output logic              Lock,
  output logic              Timeout
);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;

  localparam logic [DATA_W-1:0] THR_INIT = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W:0]   HYST_EXT = HYST[DATA_W:0];
  localparam logic [DATA_W:0]   CODE_MAX = {1'b0, {DATA_W{1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]        state;
  logic [DATA_W-1:0] thr;
  logic              level;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  hcnt;
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] run_min;
  logic [CNT_W-1:0]  ref_period;
  logic              has_ref;

  logic [DATA_W:0]   hi_sum;
  logic [DATA_W-1:0] hi_th;
  logic [DATA_W-1:0] lo_th;
  logic              next_level;
  logic              rise;
  logic              capture;
  logic              overflow;
  logic [DATA_W:0]   mid_sum;
  logic [CNT_W-1:0]  period_next;
  logic              report;

  // Hysteresis slicer with saturated thresholds and rising-edge detection.
  always_comb begin
    hi_sum = {1'b0, thr} + HYST_EXT;
    if (hi_sum > CODE_MAX) begin
      hi_th = {DATA_W{1'b1}};
    end else begin
      hi_th = hi_sum[DATA_W-1:0];
    end
    if ({1'b0, thr} < HYST_EXT) begin
      lo_th = {DATA_W{1'b0}};
    end else begin
      lo_th = thr - HYST_EXT[DATA_W-1:0];
    end
    if (Sample >= hi_th) begin
      next_level = 1'b1;
    end else if (Sample <= lo_th) begin
      next_level = 1'b0;
    end else begin
      next_level = level;
    end
    rise     = (state != S_INIT) && !level && next_level;
    capture  = Sample_Valid && (state == S_MEAS) && rise;
    overflow = Sample_Valid && (state == S_MEAS) && !rise && (cnt == CNT_MAX);
    mid_sum  = {1'b0, run_max} + {1'b0, run_min};
  end

`ifdef WAVE_AVG_EN
  logic [CNT_W-1:0] hist0;
  logic [CNT_W-1:0] hist1;
  logic [CNT_W-1:0] hist2;
  logic [1:0]       cap_cnt;
  logic [CNT_W+1:0] avg_sum;

  assign avg_sum     = {2'b00, cnt} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};
  assign period_next = avg_sum[CNT_W+1:2];
  assign report      = (cap_cnt == 2'd3);

  // Raw period history; the first three captures after reset or timeout only fill it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hist0   <= CNT_ZERO;
      hist1   <= CNT_ZERO;
      hist2   <= CNT_ZERO;
      cap_cnt <= 2'd0;
    end else if (capture) begin
      hist0 <= cnt;
      hist1 <= hist0;
      hist2 <= hist1;
      if (cap_cnt != 2'd3) begin
        cap_cnt <= cap_cnt + 2'd1;
      end
    end else if (overflow) begin
      cap_cnt <= 2'd0;
    end
  end
`else
  assign period_next = cnt;
  assign report      = 1'b1;
`endif

  // Measurement FSM, running statistics and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= S_INIT;
      thr        <= THR_INIT;
      level      <= 1'b0;
      cnt        <= CNT_ZERO;
      hcnt       <= CNT_ZERO;
      run_max    <= {DATA_W{1'b0}};
      run_min    <= {DATA_W{1'b0}};
      ref_period <= CNT_ZERO;
      has_ref    <= 1'b0;
      Period     <= CNT_ZERO;
      High_Time  <= CNT_ZERO;
      Peak_Max   <= {DATA_W{1'b0}};
      Peak_Min   <= {DATA_W{1'b0}};
      Meas_Valid <= 1'b0;
      Lock       <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      Meas_Valid <= 1'b0;
      if (Sample_Valid) begin
        level <= next_level;
        case (state)
          S_INIT: state <= S_WAIT;
          S_WAIT: begin
            if (rise) begin
              state   <= S_MEAS;
              cnt     <= CNT_ONE;
              hcnt    <= CNT_ONE;
              run_max <= Sample;
              run_min <= Sample;
            end
          end
          S_MEAS: begin
            if (rise) begin
              // Closing edge: publish, then this same sample opens the next period.
              Period     <= period_next;
              High_Time  <= hcnt;
              Peak_Max   <= run_max;
              Peak_Min   <= run_min;
              thr        <= mid_sum[DATA_W:1];
              Meas_Valid <= report;
              Timeout    <= 1'b0;
              Lock       <= has_ref && (cnt == ref_period);
              ref_period <= cnt;
              has_ref    <= 1'b1;
              cnt        <= CNT_ONE;
              hcnt       <= CNT_ONE;
              run_max    <= Sample;
              run_min    <= Sample;
            end else if (cnt == CNT_MAX) begin
              Timeout <= 1'b1;
              Lock    <= 1'b0;
              has_ref <= 1'b0;
              thr     <= THR_INIT;
              state   <= S_WAIT;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (next_level) begin
                hcnt <= hcnt + CNT_ONE;
              end
              if (Sample > run_max) begin
                run_max <= Sample;
              end
              if (Sample < run_min) begin
                run_min <= Sample;
              end
            end
          end
          default: state <= S_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_wave_analyzer.sv
// Directed bench for dds_wave_analyzer: square waves, sparse valid, noise, timeout, mid-run reset, averaging.
module tb_dds_wave_analyzer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [7:0]  sample = 8'h00;
  logic [15:0] period;
  logic [15:0] high_time;
  logic [7:0]  peak_max;
  logic [7:0]  peak_min;
  logic        meas_valid;
  logic        lock;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [15:0] period;
    logic [15:0] high;
    logic [7:0]  pmax;
    logic [7:0]  pmin;
    logic        lock;
    logic        tmo;
    int unsigned cyc;
  } meas_t;

  meas_t mq[$];
  meas_t m;

  dds_wave_analyzer dut (
    .Clk(clk), .Rst(rst), .Sample_Valid(sample_valid), .Sample(sample),
    .Period(period), .High_Time(high_time), .Peak_Max(peak_max), .Peak_Min(peak_min),
    .Meas_Valid(meas_valid), .Lock(lock), .Timeout(timeout)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every Meas_Valid pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      m.period = period; m.high = high_time; m.pmax = peak_max; m.pmin = peak_min;
      m.lock = lock; m.tmo = timeout; m.cyc = cyc;
      mq.push_back(m);
    end
  end

  task automatic step(input logic [7:0] s, input logic v);
    sample = s; sample_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b1);
  endtask

  task automatic square(input int nh, input int nl);
    run(8'hFF, nh);
    run(8'h00, nl);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(8'h00, 1'b0); step(8'h00, 1'b0);
    rst = 1'b0; mq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; step(8'h5A, 1'b1); step(8'hA5, 1'b1);
    n_cmp++; if (period !== 16'd0) begin n_bad++; $display("FAIL reset_period: got %0d want 0", period); end
    n_cmp++; if (high_time !== 16'd0) begin n_bad++; $display("FAIL reset_high: got %0d want 0", high_time); end
    n_cmp++; if (peak_max !== 8'h00) begin n_bad++; $display("FAIL reset_max: got %h want 00", peak_max); end
    n_cmp++; if (peak_min !== 8'h00) begin n_bad++; $display("FAIL reset_min: got %h want 00", peak_min); end
    n_cmp++; if ({meas_valid, lock, timeout} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {meas_valid, lock, timeout}); end
    n_cmp++; if (dut.thr !== 8'h80) begin n_bad++; $display("FAIL reset_thr: got %h want 80", dut.thr); end
    rst = 1'b0; mq.delete();
  endtask

  task automatic test_square();
    do_reset();
    run(8'h00, 128);
    for (int k = 0; k < 3; k++) square(128, 128);
    run(8'hFF, 1);
    step(8'h00, 1'b0); step(8'h00, 1'b0);
    n_cmp++; if (mq.size() != 3) begin n_bad++; $display("FAIL square_count: got %0d want 3", mq.size()); end
    for (int i = 0; i < mq.size(); i++) begin
      n_cmp++; if (mq[i].period !== 16'd256) begin n_bad++; $display("FAIL square_period[%0d]: got %0d want 256", i, mq[i].period); end
      n_cmp++; if (mq[i].high !== 16'd128) begin n_bad++; $display("FAIL square_high[%0d]: got %0d want 128", i, mq[i].high); end
      n_cmp++; if ({mq[i].pmax, mq[i].pmin} !== 16'hFF00) begin n_bad++; $display("FAIL square_peaks[%0d]: got %h/%h want FF/00", i, mq[i].pmax, mq[i].pmin); end
      n_cmp++; if (mq[i].lock !== (i > 0)) begin n_bad++; $display("FAIL square_lock[%0d]: got %b want %b", i, mq[i].lock, (i > 0)); end
      if (i > 0) begin
        n_cmp++; if (mq[i].cyc - mq[i-1].cyc != 256) begin n_bad++; $display("FAIL square_spacing[%0d]: got %0d want 256", i, mq[i].cyc - mq[i-1].cyc); end
      end
    end
    n_cmp++; if (dut.thr !== 8'h7F) begin n_bad++; $display("FAIL square_thr: got %h want 7F", dut.thr); end
  endtask

  task automatic test_sparse_valid();
    do_reset();
    for (int i = 0; i < 128; i++) begin step(8'h00, 1'b1); step(8'hFF, 1'b0); end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 128; i++) begin step(8'hFF, 1'b1); step(8'h00, 1'b0); end
      for (int i = 0; i < 128; i++) begin step(8'h00, 1'b1); step(8'hFF, 1'b0); end
    end
    step(8'hFF, 1'b1); step(8'h00, 1'b0); step(8'h00, 1'b0);
    n_cmp++; if (mq.size() != 3) begin n_bad++; $display("FAIL sparse_count: got %0d want 3", mq.size()); end
    for (int i = 0; i < mq.size(); i++) begin
      n_cmp++; if ({mq[i].period, mq[i].high} !== {16'd256, 16'd128}) begin n_bad++; $display("FAIL sparse_meas[%0d]: got %0d/%0d want 256/128", i, mq[i].period, mq[i].high); end
      if (i > 0) begin
        n_cmp++; if (mq[i].cyc - mq[i-1].cyc != 512) begin n_bad++; $display("FAIL sparse_spacing[%0d]: got %0d want 512", i, mq[i].cyc - mq[i-1].cyc); end
      end
    end
  endtask

  task automatic test_noise();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 128; i++) begin v = 8'(64 + (i % 21) - 10); step(v, 1'b1); end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 128; i++) begin v = 8'(192 + (i % 21) - 10); step(v, 1'b1); end
      for (int i = 0; i < 128; i++) begin v = 8'(64 + (i % 21) - 10); step(v, 1'b1); end
    end
    step(8'hC0, 1'b1); step(8'h00, 1'b0); step(8'h00, 1'b0);
    n_cmp++; if (mq.size() != 3) begin n_bad++; $display("FAIL noise_count: got %0d want 3", mq.size()); end
    for (int i = 0; i < mq.size(); i++) begin
      n_cmp++; if ({mq[i].period, mq[i].high} !== {16'd256, 16'd128}) begin n_bad++; $display("FAIL noise_meas[%0d]: got %0d/%0d want 256/128", i, mq[i].period, mq[i].high); end
      n_cmp++; if ({mq[i].pmax, mq[i].pmin} !== 16'hCA36) begin n_bad++; $display("FAIL noise_peaks[%0d]: got %h/%h want CA/36", i, mq[i].pmax, mq[i].pmin); end
    end
    n_cmp++; if (dut.thr !== 8'h80) begin n_bad++; $display("FAIL noise_thr: got %h want 80", dut.thr); end
  endtask

  task automatic test_timeout();
    do_reset();
    run(8'h00, 128);
    square(128, 128); square(128, 128);
    run(8'hFF, 1);
    n_cmp++; if ({period, lock} !== {16'd256, 1'b1}) begin n_bad++; $display("FAIL tmo_pre: got %0d/%b want 256/1", period, lock); end
    run(8'hFF, 65534);
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_edge_of_range: got %b want 0", timeout); end
    run(8'hFF, 1);
    n_cmp++; if ({timeout, lock} !== 2'b10) begin n_bad++; $display("FAIL tmo_set: got %b want 10", {timeout, lock}); end
    n_cmp++; if (period !== 16'd256) begin n_bad++; $display("FAIL tmo_period_kept: got %0d want 256", period); end
    n_cmp++; if (dut.thr !== 8'h80) begin n_bad++; $display("FAIL tmo_thr: got %h want 80", dut.thr); end
    mq.delete();
    run(8'h00, 128); run(8'hFF, 128); run(8'h00, 128);
    n_cmp++; if (timeout !== 1'b1 || mq.size() != 0) begin n_bad++; $display("FAIL tmo_held: got %b/%0d want 1/0", timeout, mq.size()); end
    run(8'hFF, 1); step(8'h00, 1'b0);
    n_cmp++; if (mq.size() != 1) begin n_bad++; $display("FAIL tmo_recover_count: got %0d want 1", mq.size()); end
    if (mq.size() == 1) begin
      n_cmp++; if ({mq[0].period, mq[0].tmo, mq[0].lock} !== {16'd256, 2'b00}) begin n_bad++; $display("FAIL tmo_recover: got %0d/%b/%b want 256/0/0", mq[0].period, mq[0].tmo, mq[0].lock); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run(8'h00, 128);
    square(128, 128); square(128, 128);
    run(8'hFF, 60); run(8'h00, 128);
    n_cmp++; if (mq.size() != 2 || period !== 16'd256) begin n_bad++; $display("FAIL rstmid_pre: got %0d/%0d want 2/256", mq.size(), period); end
    rst = 1'b1; step(8'hFF, 1'b1); rst = 1'b0;
    n_cmp++; if ({period, high_time, peak_max, peak_min} !== 48'd0) begin n_bad++; $display("FAIL rstmid_outputs: got %0d/%0d/%h/%h want 0", period, high_time, peak_max, peak_min); end
    n_cmp++; if ({meas_valid, lock, timeout} !== 3'b000) begin n_bad++; $display("FAIL rstmid_flags: got %b want 000", {meas_valid, lock, timeout}); end
    step(8'h00, 1'b0);
    n_cmp++; if (mq.size() != 2) begin n_bad++; $display("FAIL rstmid_no_pulse: got %0d want 2", mq.size()); end
    mq.delete();
    run(8'hFF, 128); run(8'h00, 128); run(8'hFF, 128); run(8'h00, 128);
    n_cmp++; if (mq.size() != 0) begin n_bad++; $display("FAIL rstmid_init_edge: got %0d want 0", mq.size()); end
    run(8'hFF, 1); step(8'h00, 1'b0);
    n_cmp++; if (mq.size() != 1) begin n_bad++; $display("FAIL rstmid_second_edge: got %0d want 1", mq.size()); end
    if (mq.size() == 1) begin
      n_cmp++; if ({mq[0].period, mq[0].lock} !== {16'd256, 1'b0}) begin n_bad++; $display("FAIL rstmid_meas: got %0d/%b want 256/0", mq[0].period, mq[0].lock); end
    end
  endtask

  task automatic test_periods();
    do_reset();
    run(8'h00, 128);
    square(128, 128); square(128, 128); square(130, 130); square(130, 130);
    run(8'hFF, 1); step(8'h00, 1'b0);
`ifdef WAVE_AVG_EN
    n_cmp++; if (mq.size() != 1) begin n_bad++; $display("FAIL avg_count: got %0d want 1", mq.size()); end
    if (mq.size() == 1) begin
      n_cmp++; if ({mq[0].period, mq[0].high, mq[0].lock} !== {16'd258, 16'd130, 1'b1}) begin n_bad++; $display("FAIL avg_meas: got %0d/%0d/%b want 258/130/1", mq[0].period, mq[0].high, mq[0].lock); end
    end
`else
    n_cmp++; if (mq.size() != 4) begin n_bad++; $display("FAIL periods_count: got %0d want 4", mq.size()); end
    if (mq.size() == 4) begin
      n_cmp++; if (mq[2].period !== 16'd260 || mq[2].lock !== 1'b0) begin n_bad++; $display("FAIL periods_change: got %0d/%b want 260/0", mq[2].period, mq[2].lock); end
      n_cmp++; if (mq[3].period !== 16'd260 || mq[3].lock !== 1'b1) begin n_bad++; $display("FAIL periods_relock: got %0d/%b want 260/1", mq[3].period, mq[3].lock); end
      n_cmp++; if (mq[3].high !== 16'd130) begin n_bad++; $display("FAIL periods_high: got %0d want 130", mq[3].high); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_square();
    test_sparse_valid();
    test_noise();
    test_reset_mid();
    test_periods();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
